// File: rtl/arithmetic_left_shift_seq_10bit_if.sv
// ============================================================================
// Module   : arithmetic_left_shift_seq_10bit_if
// Brief    : start/busy/done handshake and data bundle for the sequential shifter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface arithmetic_left_shift_seq_10bit_if #(
  parameter int WIDTH = 10,
  parameter int SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   amt;
  logic             sat_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             ovf;

  modport master (
    output start, din, amt, sat_en,
    input  busy, done, dout, ovf
  );

  modport slave (
    input  start, din, amt, sat_en,
    output busy, done, dout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/arithmetic_left_shift_seq_10bit.sv
// ============================================================================
// Module   : arithmetic_left_shift_seq_10bit
// Brief    : one-bit-per-clock signed left shifter with sticky overflow/saturation
// Revision : 1.0
// ============================================================================
`default_nettype none

module arithmetic_left_shift_seq_10bit #(
  parameter int WIDTH = 10,
  parameter int SHW   = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  arithmetic_left_shift_seq_10bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [SHW-1:0]   cnt_q,     cnt_d;
  logic             sign0_q,   sign0_d;
  logic             sat_q,     sat_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] dout_q,    dout_d;
  logic             ovf_q,     ovf_d;
  logic             done_q,    done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sign0_q   <= 1'b0;
      sat_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sign0_q   <= sign0_d;
      sat_q     <= sat_d;
      ovf_acc_q <= ovf_acc_d;
      dout_q    <= dout_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sign0_d   = sign0_q;
    sat_d     = sat_q;
    ovf_acc_d = ovf_acc_q;
    dout_d    = dout_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d     = bus.din;
          cnt_d     = bus.amt;
          sign0_d   = bus.din[WIDTH-1];
          sat_d     = bus.sat_en;
          ovf_acc_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          // Overflow is judged on the word before it moves, so any sign flip sticks.
          ovf_acc_d = ovf_acc_q | (acc_q[WIDTH-1] ^ acc_q[WIDTH-2]);
          acc_d     = {acc_q[WIDTH-2:0], 1'b0};
          cnt_d     = cnt_q - SHW'(1);
        end else begin
          dout_d  = (sat_q && ovf_acc_q) ? (sign0_q ? C_MIN_NEG : C_MAX_POS) : acc_q;
          ovf_d   = ovf_acc_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.dout = dout_q;
  assign bus.ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_arithmetic_left_shift_seq_10bit.sv
// ============================================================================
// Module   : tb_arithmetic_left_shift_seq_10bit
// Brief    : directed scoreboard bench for the sequential arithmetic left shifter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arithmetic_left_shift_seq_10bit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  arithmetic_left_shift_seq_10bit_if #(.WIDTH(10), .SHW(4)) bus ();

  arithmetic_left_shift_seq_10bit #(.WIDTH(10), .SHW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] dout;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: every done pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done dout=%h ovf=%b want no done", bus.dout, bus.ovf);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (bus.dout !== e.dout || bus.ovf !== e.ovf) begin
            n_err++;
            $display("FAIL result got dout=%h ovf=%b want dout=%h ovf=%b",
                     bus.dout, bus.ovf, e.dout, e.ovf);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Issue one operation (called at #1 after a posedge with the DUT idle);
  // checks latency and busy width, optionally pokes start while busy.
  task automatic run(input logic [9:0] din, input logic [3:0] amt, input logic sat,
                     input logic [9:0] exp_dout, input logic exp_ovf, input logic inj);
    int k = 0;
    int busy_cnt = 0;
    int done_at = -1;
    bus.din = din; bus.amt = amt; bus.sat_en = sat; bus.start = 1'b1;
    exp_q.push_back('{dout: exp_dout, ovf: exp_ovf});
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.din = 10'(~din); bus.amt = 4'(~amt); bus.sat_en = ~sat;
    while (bus.busy) begin
      busy_cnt++;
      if (bus.done && done_at < 0) done_at = k;
      if (inj) bus.start = (k == 1) || (bus.done === 1'b1);
      if (k > 40) begin
        n_cmp++; n_err++;
        $display("FAIL timeout busy stuck got %0d cycles want %0d", k, amt + 2);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check("done_latency", 32'(done_at), 32'(amt) + 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(amt) + 32'd2);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.din = '0; bus.amt = '0; bus.sat_en = 1'b0;
    rst = 1'b1;
    idle_cycles(3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    idle_cycles(2);

    run(10'h003, 4'd2,  1'b0, 10'h00C, 1'b0, 1'b0);
    run(10'h3FF, 4'd9,  1'b0, 10'h200, 1'b0, 1'b0);
    run(10'h100, 4'd1,  1'b0, 10'h200, 1'b1, 1'b0);
    run(10'h100, 4'd1,  1'b1, 10'h1FF, 1'b1, 1'b0);
    run(10'h280, 4'd1,  1'b1, 10'h200, 1'b1, 1'b0);
    run(10'h155, 4'd0,  1'b0, 10'h155, 1'b0, 1'b1);
    idle_cycles(8);
    run(10'h021, 4'd3,  1'b1, 10'h108, 1'b0, 1'b1);
    idle_cycles(8);
    run(10'h001, 4'd12, 1'b0, 10'h000, 1'b1, 1'b0);
    run(10'h001, 4'd12, 1'b1, 10'h1FF, 1'b1, 1'b0);
    run(10'h3F0, 4'd15, 1'b1, 10'h200, 1'b1, 1'b0);
    run(10'h000, 4'd15, 1'b1, 10'h000, 1'b0, 1'b0);
    run(10'h0A5, 4'd1,  1'b0, 10'h14A, 1'b0, 1'b0);

    // Abort mid-shift: previous dout is nonzero, so reset must clear it.
    bus.din = 10'h001; bus.amt = 4'd8; bus.sat_en = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dout", 32'(bus.dout), 32'd0);
    check("abort_ovf",  32'(bus.ovf),  32'd0);
    rst = 1'b0;
    idle_cycles(15);
    run(10'h001, 4'd8, 1'b0, 10'h100, 1'b0, 1'b0);
    idle_cycles(3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
